// File: rtl/tbird_seq_gen.sv
// rtl/tbird_seq_gen.sv - parametrised T-Bird tail-light sequencer with hazard, brake and mode letter
// Switches are synchronised, decoded to a mode, and drive a stepped lamp phase; all outputs registered.
module tbird_seq_gen #(
    parameter int LAMPS       = 3,
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw0,
    input  logic               sw1,
    input  logic               sw_haz,
    input  logic               sw_brake,
    output logic [2*LAMPS-1:0] leds,
    output logic [6:0]         seg,
    output logic [2:0]         mode,
    output logic               step
);

    localparam int TICK_W  = $clog2(STEP_CYCLES);
    localparam int PHASE_W = $clog2(LAMPS + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(STEP_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(LAMPS);

    localparam logic [2:0] MODE_IDLE   = 3'd0;
    localparam logic [2:0] MODE_RIGHT  = 3'd1;
    localparam logic [2:0] MODE_LEFT   = 3'd2;
    localparam logic [2:0] MODE_HAZARD = 3'd3;
    localparam logic [2:0] MODE_ERROR  = 3'd4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Switch bit order in both synchroniser stages: {brake, hazard, left, right}
    logic [3:0]         sync1_q, sync1_d;
    logic [3:0]         sync2_q, sync2_d;
    logic [2:0]         mode_q, mode_d;
    logic               brake_q, brake_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               step_q, step_d;
    logic [2*LAMPS-1:0] leds_q, leds_d;
    logic [6:0]         seg_q, seg_d;

    logic               mode_change;
    logic               tick_wrap;
    logic [LAMPS-1:0]   seq_mask;
    logic [LAMPS-1:0]   right_side;
    logic [LAMPS-1:0]   left_side;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            mode_q  <= MODE_IDLE;
            brake_q <= 1'b0;
            tick_q  <= '0;
            phase_q <= '0;
            step_q  <= 1'b0;
            leds_q  <= '0;
            seg_q   <= SEG_BLANK;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            mode_q  <= mode_d;
            brake_q <= brake_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            leds_q  <= leds_d;
            seg_q   <= seg_d;
        end
    end

    // Next-state logic
    always_comb begin
        sync1_d = {sw_brake, sw_haz, sw1, sw0};
        sync2_d = sync1_q;
        brake_d = sync2_q[3];

        if (sync2_q[2]) begin
            mode_d = MODE_HAZARD;
        end else if (sync2_q[1] && sync2_q[0]) begin
            mode_d = MODE_ERROR;
        end else if (sync2_q[0]) begin
            mode_d = MODE_RIGHT;
        end else if (sync2_q[1]) begin
            mode_d = MODE_LEFT;
        end else begin
            mode_d = MODE_IDLE;
        end

        mode_change = (mode_d != mode_q);
        tick_wrap   = (tick_q == TICK_LAST);

        // A mode load restarts the step timing; any step due on the same edge is dropped.
        if (mode_change || tick_wrap) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end
        step_d = (tick_d == TICK_LAST);

        phase_d = phase_q;
        if (mode_change) begin
            phase_d = '0;
        end else if (tick_wrap) begin
            case (mode_q)
                MODE_RIGHT, MODE_LEFT:
                    phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
                MODE_HAZARD, MODE_ERROR:
                    phase_d = (phase_q == '0) ? PHASE_W'(1) : '0;
                default:
                    phase_d = '0;
            endcase
        end
    end

    // Output logic
    always_comb begin
        for (int i = 0; i < LAMPS; i++) begin
            seq_mask[i] = (i < int'(phase_q));
        end

        right_side = '0;
        left_side  = '0;
        seg_d      = SEG_BLANK;

        case (mode_q)
            MODE_RIGHT: begin
                right_side = seq_mask;
                left_side  = brake_q ? '1 : '0;
                seg_d      = SEG_R;
            end
            MODE_LEFT: begin
                left_side  = seq_mask;
                right_side = brake_q ? '1 : '0;
                seg_d      = SEG_L;
            end
            MODE_HAZARD: begin
                right_side = phase_q[0] ? '1 : '0;
                left_side  = phase_q[0] ? '1 : '0;
                seg_d      = SEG_H;
            end
            MODE_ERROR: begin
                right_side = phase_q[0] ? '0 : '1;
                left_side  = phase_q[0] ? '1 : '0;
                seg_d      = SEG_E;
            end
            default: begin
                right_side = brake_q ? '1 : '0;
                left_side  = brake_q ? '1 : '0;
                seg_d      = SEG_BLANK;
            end
        endcase

        leds_d = {left_side, right_side};
    end

    assign leds = leds_q;
    assign seg  = seg_q;
    assign mode = mode_q;
    assign step = step_q;

endmodule

// File: tb/tb_tbird_seq_gen.sv
// tb/tb_tbird_seq_gen.sv - directed self-checking bench for tbird_seq_gen (LAMPS=3, STEP_CYCLES=4)
module tb_tbird_seq_gen;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    logic       clk;
    logic       rst_n;
    logic       sw0;
    logic       sw1;
    logic       sw_haz;
    logic       sw_brake;
    logic [5:0] leds;
    logic [6:0] seg;
    logic [2:0] mode;
    logic       step;

    int checks;
    int failures;

    tbird_seq_gen #(
        .LAMPS      (3),
        .STEP_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw0     (sw0),
        .sw1     (sw1),
        .sw_haz  (sw_haz),
        .sw_brake(sw_brake),
        .leds    (leds),
        .seg     (seg),
        .mode    (mode),
        .step    (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        sw0      = 1'b0;
        sw1      = 1'b0;
        sw_haz   = 1'b0;
        sw_brake = 1'b0;

        clk_n(2);
        chk("rst_leds", leds, 6'b000000);
        chk("rst_seg", seg, SEG_BLANK);
        chk("rst_mode", mode, 3'd0);
        chk("rst_step", step, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            clk_n(1);
            chk("idle_leds", leds, 6'b000000);
            chk("idle_mode", mode, 3'd0);
            chk("idle_seg", seg, SEG_BLANK);
        end

        // Right sequence: edges counted from the switch change
        sw0 = 1'b1;
        clk_n(2);
        chk("right_mode_e2", mode, 3'd0);
        clk_n(1);
        chk("right_mode_e3", mode, 3'd1);
        chk("right_step_e3", step, 1'b0);
        clk_n(1);
        chk("right_seg_e4", seg, SEG_R);
        chk("right_leds_e4", leds, 6'b000000);
        clk_n(2);
        chk("right_step_e6", step, 1'b1);
        clk_n(1);
        chk("right_step_e7", step, 1'b0);
        clk_n(1);
        chk("right_leds_e8", leds, 6'b000001);
        clk_n(2);
        chk("right_step_e10", step, 1'b1);
        clk_n(2);
        chk("right_leds_e12", leds, 6'b000011);

        // Switch to left at phase 2; the load edge coincides with a step
        sw0 = 1'b0;
        sw1 = 1'b1;
        clk_n(2);
        chk("mid_mode_f2", mode, 3'd1);
        chk("mid_step_f2", step, 1'b1);
        clk_n(1);
        chk("mid_mode_f3", mode, 3'd2);
        chk("mid_step_f3", step, 1'b0);
        chk("mid_leds_f3", leds, 6'b000011);
        clk_n(1);
        chk("mid_leds_f4", leds, 6'b000000);
        chk("mid_seg_f4", seg, SEG_L);
        clk_n(4);
        chk("left_leds_f8", leds, 6'b001000);
        clk_n(4);
        chk("left_leds_f12", leds, 6'b011000);
        clk_n(4);
        chk("left_leds_f16", leds, 6'b111000);
        clk_n(4);
        chk("left_leds_f20", leds, 6'b000000);

        // Error mode, then brake (ignored), then hazard priority
        sw0 = 1'b1;
        clk_n(3);
        chk("err_mode", mode, 3'd4);
        clk_n(1);
        chk("err_leds_g4", leds, 6'b000111);
        chk("err_seg", seg, SEG_E);
        clk_n(4);
        chk("err_leds_g8", leds, 6'b111000);
        clk_n(4);
        chk("err_leds_g12", leds, 6'b000111);
        sw_brake = 1'b1;
        clk_n(4);
        chk("err_brake_g16", leds, 6'b111000);
        sw_haz = 1'b1;
        clk_n(3);
        chk("haz_mode", mode, 3'd3);
        clk_n(1);
        chk("haz_leds_h4", leds, 6'b000000);
        chk("haz_seg", seg, SEG_H);
        clk_n(4);
        chk("haz_leds_h8", leds, 6'b111111);
        clk_n(4);
        chk("haz_leds_h12", leds, 6'b000000);

        // Idle with brake
        sw_haz = 1'b0;
        sw0    = 1'b0;
        sw1    = 1'b0;
        clk_n(3);
        chk("brk_idle_mode", mode, 3'd0);
        clk_n(1);
        chk("brk_idle_leds", leds, 6'b111111);
        chk("brk_idle_seg", seg, SEG_BLANK);

        // Brake applied and released during a right sequence
        sw_brake = 1'b0;
        sw0      = 1'b1;
        clk_n(3);
        chk("brk_right_mode", mode, 3'd1);
        clk_n(1);
        chk("brk_right_j4", leds, 6'b000000);
        clk_n(4);
        chk("brk_right_j8", leds, 6'b000001);
        clk_n(4);
        chk("brk_right_j12", leds, 6'b000011);
        sw_brake = 1'b1;
        clk_n(2);
        chk("brk_right_j14", leds, 6'b000011);
        clk_n(2);
        chk("brk_right_j16", leds, 6'b111111);
        clk_n(4);
        chk("brk_right_j20", leds, 6'b111000);
        sw_brake = 1'b0;
        clk_n(4);
        chk("brk_right_j24", leds, 6'b000001);
        chk("brk_right_mode_j24", mode, 3'd1);

        // Asynchronous reset in the middle of a hazard sequence
        sw0    = 1'b0;
        sw_haz = 1'b1;
        clk_n(3);
        chk("rhaz_mode", mode, 3'd3);
        clk_n(5);
        chk("rhaz_leds_l8", leds, 6'b111111);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_leds", leds, 6'b000000);
        chk("arst_mode", mode, 3'd0);
        chk("arst_seg", seg, SEG_BLANK);
        chk("arst_step", step, 1'b0);
        clk_n(1);
        chk("arst_hold_leds", leds, 6'b000000);
        rst_n = 1'b1;
        clk_n(2);
        chk("rel_mode_m2", mode, 3'd0);
        clk_n(1);
        chk("rel_mode_m3", mode, 3'd3);
        chk("rel_leds_m3", leds, 6'b000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
